// File: rtl/cl_mcl_pkg.sv
// Shared definitions for the manycore-link AXI-Lite bridge (rx and tx sides).
//   axil_base_addr_p    : base of the FIFO window region on the ocl port
//   base_addr_width_p   : width of the offset field inside one FIFO window
//   index_addr_width_lp : width of the FIFO index field above the offset
//   ofs_tdr_lp          : offset of the transmit data register in a window
//   wr_state_e          : tx write-channel FSM states
//   axil_resp_e         : AXI-Lite B/R response codes
package cl_mcl_pkg;

    localparam logic [31:0] axil_base_addr_p    = 32'h0000_0000;
    localparam int          base_addr_width_p   = 8;
    localparam int          index_addr_width_lp = 8;
    localparam int          window_top_lp       = base_addr_width_p + index_addr_width_lp;

    localparam logic [base_addr_width_p-1:0] ofs_tdr_lp = 8'h10;

    typedef enum logic [1:0] {
        E_WR_IDLE,
        E_WR_PUSH,
        E_WR_REG,
        E_WR_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

endpackage

// File: rtl/bsg_axil_tx_addr_decode.sv
// Combinational AXI-Lite address decoder for the FIFO windows.
//   addr_i    : byte address from the AW channel
//   idx_o     : FIFO index relative to the window base
//   fifo_v_o  : address hits the TDR offset of an existing FIFO window
//   reg_v_o   : address hits any other offset of an existing FIFO window
//   dec_err_o : address is outside every FIFO window
module bsg_axil_tx_addr_decode
    import cl_mcl_pkg::*;
#(
    parameter int num_fifos_p = 1
) (
    input  logic [31:0]                    addr_i,
    output logic [index_addr_width_lp-1:0] idx_o,
    output logic                           fifo_v_o,
    output logic                           reg_v_o,
    output logic                           dec_err_o
);

    localparam logic [index_addr_width_lp-1:0] base_idx_lp =
        index_addr_width_lp'(axil_base_addr_p >> base_addr_width_p);

    logic in_region;
    logic idx_ok;
    logic is_tdr;

    always_comb begin
        idx_o     = addr_i[base_addr_width_p +: index_addr_width_lp] - base_idx_lp;
        // Bits above the index field must match the base, otherwise an alias
        // far above the region would land on a real FIFO.
        in_region = (addr_i[31:window_top_lp] == axil_base_addr_p[31:window_top_lp]);
        idx_ok    = in_region && (32'(idx_o) < num_fifos_p);
        is_tdr    = (addr_i[base_addr_width_p-1:0] == ofs_tdr_lp);
        fifo_v_o  = idx_ok & is_tdr;
        reg_v_o   = idx_ok & ~is_tdr;
        dec_err_o = ~idx_ok;
    end

endmodule

// File: rtl/bsg_axil_to_fifos_tx.sv
// AXI-Lite write-channel slave that turns host writes into pushes on
// num_fifos_p outbound 32-bit valid/ready FIFO interfaces. Writes to the TDR
// offset of a window push that FIFO; other offsets in a window produce a
// one-cycle register-write strobe; addresses outside all windows get DECERR.
// One write is in flight at a time; all outputs are registered.
//
// Ports:
//   clk_i, reset_n_i                  clock, async active-low reset
//   awaddr_i/awvalid_i/awready_o      AW channel
//   wdata_i/wstrb_i/wvalid_i/wready_o W channel
//   bresp_o/bvalid_o/bready_i         B channel
//   tx_v_o[N], tx_data_o[N*32], tx_ready_i[N]  FIFO push interfaces
//   wr_v_o, wr_addr_o, wr_data_o      register-write strobe
//
// Build option:
//   BSG_AXIL_TX_WSTRB_CHECK_EN : partial-strobe writes to a FIFO/register
//   window are rejected with SLVERR and have no side effects. When undefined
//   the strobe is ignored and the full word is written.
module bsg_axil_to_fifos_tx
    import cl_mcl_pkg::*;
#(
    parameter int num_fifos_p = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic [31:0]               awaddr_i,
    input  logic                      awvalid_i,
    output logic                      awready_o,

    input  logic [31:0]               wdata_i,
    input  logic [3:0]                wstrb_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,

    output logic [1:0]                bresp_o,
    output logic                      bvalid_o,
    input  logic                      bready_i,

    output logic [num_fifos_p-1:0]    tx_v_o,
    output logic [num_fifos_p*32-1:0] tx_data_o,
    input  logic [num_fifos_p-1:0]    tx_ready_i,

    output logic                      wr_v_o,
    output logic [31:0]               wr_addr_o,
    output logic [31:0]               wr_data_o
);

`ifdef BSG_AXIL_TX_WSTRB_CHECK_EN
    localparam bit strb_check_lp = 1'b1;
`else
    localparam bit strb_check_lp = 1'b0;
`endif

    wr_state_e  state_q;
    logic       aw_got_q, w_got_q;
    logic [31:0] addr_q, data_q;
    logic [3:0] strb_q;
    logic       awready_q, wready_q;
    logic       bvalid_q;
    axil_resp_e bresp_q;
    logic [num_fifos_p-1:0] tx_v_q;
    logic       wr_v_q;
    logic [31:0] wr_addr_q, wr_data_q;

    logic        aw_hs, w_hs, both_got, strb_err;
    logic [31:0] cur_addr, cur_data;
    logic [3:0]  cur_strb;
    logic [index_addr_width_lp-1:0] dec_idx;
    logic        dec_fifo_v, dec_reg_v, dec_err;
    logic [num_fifos_p-1:0] dec_oh;

    // Decode sees the address of a handshake completing this cycle so a
    // write with AW and W together can leave IDLE on that same edge.
    bsg_axil_tx_addr_decode #(
        .num_fifos_p(num_fifos_p)
    ) u_decode (
        .addr_i   (cur_addr),
        .idx_o    (dec_idx),
        .fifo_v_o (dec_fifo_v),
        .reg_v_o  (dec_reg_v),
        .dec_err_o(dec_err)
    );

    always_comb begin
        aw_hs    = awvalid_i & awready_q;
        w_hs     = wvalid_i & wready_q;
        cur_addr = aw_hs ? awaddr_i : addr_q;
        cur_data = w_hs ? wdata_i : data_q;
        cur_strb = w_hs ? wstrb_i : strb_q;
        both_got = (aw_got_q | aw_hs) & (w_got_q | w_hs);
        strb_err = strb_check_lp & (cur_strb != 4'hF);
        dec_oh   = '0;
        for (int i = 0; i < num_fifos_p; i++) begin
            dec_oh[i] = dec_fifo_v & (dec_idx == index_addr_width_lp'(i));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= E_WR_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            tx_v_q    <= '0;
            wr_v_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            case (state_q)
                E_WR_IDLE: begin
                    if (aw_hs) begin
                        addr_q   <= awaddr_i;
                        aw_got_q <= 1'b1;
                    end
                    if (w_hs) begin
                        data_q  <= wdata_i;
                        strb_q  <= wstrb_i;
                        w_got_q <= 1'b1;
                    end
                    if (both_got) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        if (dec_err) begin
                            bresp_q  <= DECERR;
                            bvalid_q <= 1'b1;
                            state_q  <= E_WR_RESP;
                        end else if (strb_err) begin
                            bresp_q  <= SLVERR;
                            bvalid_q <= 1'b1;
                            state_q  <= E_WR_RESP;
                        end else if (dec_fifo_v) begin
                            tx_v_q  <= dec_oh;
                            state_q <= E_WR_PUSH;
                        end else if (dec_reg_v) begin
                            wr_v_q    <= 1'b1;
                            wr_addr_q <= cur_addr;
                            wr_data_q <= cur_data;
                            state_q   <= E_WR_REG;
                        end
                    end else begin
                        awready_q <= ~(aw_got_q | aw_hs);
                        wready_q  <= ~(w_got_q | w_hs);
                    end
                end
                E_WR_PUSH: begin
                    // tx_v_q is one-hot on the target lane, so it also selects
                    // which ready completes the push.
                    if (|(tx_v_q & tx_ready_i)) begin
                        tx_v_q   <= '0;
                        bresp_q  <= OKAY;
                        bvalid_q <= 1'b1;
                        state_q  <= E_WR_RESP;
                    end
                end
                E_WR_REG: begin
                    wr_v_q    <= 1'b0;
                    wr_addr_q <= '0;
                    wr_data_q <= '0;
                    bresp_q   <= OKAY;
                    bvalid_q  <= 1'b1;
                    state_q   <= E_WR_RESP;
                end
                E_WR_RESP: begin
                    if (bready_i) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= OKAY;
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        state_q   <= E_WR_IDLE;
                    end
                end
                default: state_q <= E_WR_IDLE;
            endcase
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign tx_v_o    = tx_v_q;
    assign tx_data_o = {num_fifos_p{data_q}};
    assign wr_v_o    = wr_v_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: tb/tb_bsg_axil_to_fifos_tx.sv
// Bench for bsg_axil_to_fifos_tx with two FIFOs, 256-byte windows at 0,
// TDR at offset 0x10. Directed writes first, then randomized writes; each
// write's outcome is predicted from the address map alone.
module tb_bsg_axil_to_fifos_tx;

    localparam int N = 2;

`ifdef BSG_AXIL_TX_WSTRB_CHECK_EN
    localparam bit strb_chk = 1'b1;
`else
    localparam bit strb_chk = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic [31:0]   awaddr_i;
    logic          awvalid_i;
    logic          awready_o;
    logic [31:0]   wdata_i;
    logic [3:0]    wstrb_i;
    logic          wvalid_i;
    logic          wready_o;
    logic [1:0]    bresp_o;
    logic          bvalid_o;
    logic          bready_i;
    logic [N-1:0]  tx_v_o;
    logic [N*32-1:0] tx_data_o;
    logic [N-1:0]  tx_ready_i;
    logic          wr_v_o;
    logic [31:0]   wr_addr_o;
    logic [31:0]   wr_data_o;

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    bsg_axil_to_fifos_tx #(.num_fifos_p(N)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .awaddr_i  (awaddr_i),
        .awvalid_i (awvalid_i),
        .awready_o (awready_o),
        .wdata_i   (wdata_i),
        .wstrb_i   (wstrb_i),
        .wvalid_i  (wvalid_i),
        .wready_o  (wready_o),
        .bresp_o   (bresp_o),
        .bvalid_o  (bvalid_o),
        .bready_i  (bready_i),
        .tx_v_o    (tx_v_o),
        .tx_data_o (tx_data_o),
        .tx_ready_i(tx_ready_i),
        .wr_v_o    (wr_v_o),
        .wr_addr_o (wr_addr_o),
        .wr_data_o (wr_data_o)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] all_outs();
        return {awready_o, wready_o, bresp_o, bvalid_o, tx_v_o, tx_data_o,
                wr_v_o, wr_addr_o, wr_data_o};
    endfunction

    // kind: 0 = response only, 1 = FIFO push on lane, 2 = register strobe
    function automatic void model(input logic [31:0] addr, input logic [3:0] strb,
                                  output int kind, output int lane, output logic [1:0] resp);
        int unsigned win;
        int unsigned ofs;
        win  = addr / 256;
        ofs  = addr % 256;
        lane = 0;
        if (win >= N) begin
            kind = 0; resp = 2'b11;
        end else if (strb_chk && strb != 4'hF) begin
            kind = 0; resp = 2'b10;
        end else if (ofs == 16) begin
            kind = 1; lane = int'(win); resp = 2'b00;
        end else begin
            kind = 2; resp = 2'b00;
        end
    endfunction

    // Starts and ends just after a rising edge.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int stall, input int bstall);
        int kind, lane, cyc;
        logic [1:0] resp;
        bit aw_done, w_done, aw_fire, w_fire;
        logic [N-1:0] exp_v;
        model(addr, strb, kind, lane, resp);
        tx_ready_i = N'($urandom);
        if (kind == 1) tx_ready_i[lane] = (stall == 0);
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 200) begin
            awvalid_i = !aw_done && cyc >= aw_dly;
            wvalid_i  = !w_done && cyc >= w_dly;
            awaddr_i  = addr;
            wdata_i   = data;
            wstrb_i   = strb;
            @(negedge clk_i);
            if (w_done && !aw_done) chk("wready_after_w", wready_o, 0);
            if (aw_done && !w_done) chk("awready_after_aw", awready_o, 0);
            aw_fire = awvalid_i & awready_o;
            w_fire  = wvalid_i & wready_o;
            @(posedge clk_i); #1;
            aw_done |= aw_fire;
            w_done  |= w_fire;
            cyc++;
        end
        awvalid_i = 0;
        wvalid_i  = 0;
        if (!(aw_done && w_done)) begin
            chk("aw_w_timeout", 0, 1);
            return;
        end
        @(negedge clk_i);
        if (kind == 1) begin
            exp_v = N'(1) << lane;
            for (int c = 0; c <= stall; c++) begin
                chk("tx_v", tx_v_o, exp_v);
                chk("tx_data", tx_data_o[lane*32 +: 32], data);
                chk("push_backpressure", {awready_o, wready_o, bvalid_o, wr_v_o}, 0);
                @(posedge clk_i); #1;
                if (c + 1 == stall) tx_ready_i[lane] = 1'b1;
                @(negedge clk_i);
            end
        end else if (kind == 2) begin
            chk("wr_v", wr_v_o, 1);
            chk("wr_addr", wr_addr_o, addr);
            chk("wr_data", wr_data_o, data);
            chk("reg_no_tx_no_b", {tx_v_o, bvalid_o}, 0);
            @(negedge clk_i);
            chk("wr_v_one_cycle", {wr_v_o, wr_addr_o, wr_data_o}, 0);
        end
        chk("bvalid", bvalid_o, 1);
        chk("bresp", bresp_o, resp);
        chk("b_no_side", {tx_v_o, wr_v_o}, 0);
        for (int b = 0; b < bstall; b++) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk("bvalid_hold", bvalid_o, 1);
            chk("bresp_hold", bresp_o, resp);
        end
        @(posedge clk_i); #1;
        bready_i = 1'b1;
        @(negedge clk_i);
        chk("b_hs_no_accept", {awready_o, wready_o, bvalid_o}, 3'b001);
        @(posedge clk_i); #1;
        bready_i = 1'b0;
        @(negedge clk_i);
        chk("idle_after_b", {awready_o, wready_o, bvalid_o}, 3'b110);
        @(posedge clk_i); #1;
    endtask

    initial begin
        reset_n_i = 1'b1;
        awaddr_i = '0; awvalid_i = 0; wdata_i = '0; wstrb_i = '0; wvalid_i = 0;
        bready_i = 0; tx_ready_i = '0;
        #1 reset_n_i = 1'b0;
        #1 chk("reset_outputs", all_outs(), 0);
        repeat (2) @(negedge clk_i);
        chk("reset_outputs_held", all_outs(), 0);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;

        // push lane 0, AW and W together
        do_write(32'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        // W first, AW three cycles later, lane 1 full for 5 cycles
        do_write(32'h110, 32'h12345678, 4'hF, 3, 0, 5, 0);
        // register strobe
        do_write(32'h104, 32'h000000A5, 4'hF, 0, 0, 0, 0);
        // out-of-range window, B stalled 4 cycles
        do_write(32'h310, 32'hCAFEF00D, 4'hF, 0, 0, 0, 4);
        // partial strobe
        do_write(32'h010, 32'h0BADBEEF, 4'h3, 0, 0, 0, 0);

        // reset while a push is stalled
        tx_ready_i = '0;
        awaddr_i = 32'h010; wdata_i = 32'h55AA55AA; wstrb_i = 4'hF;
        awvalid_i = 1; wvalid_i = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (tx_v_o != 0) break;
        end
        awvalid_i = 0; wvalid_i = 0;
        chk("pre_reset_push", tx_v_o, 2'b01);
        #2 reset_n_i = 1'b0;
        #1 chk("reset_mid_push", all_outs(), 0);
        repeat (2) @(negedge clk_i);
        chk("reset_mid_push_held", all_outs(), 0);
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        do_write(32'h110, 32'h0F0F0F0F, 4'hF, 1, 2, 1, 1);

        for (int t = 0; t < 30; t++) begin
            logic [31:0] a;
            logic [3:0]  s;
            a = ($urandom_range(0, 3) << 8) |
                (($urandom_range(0, 1) == 1) ? 32'h10 : 32'($urandom_range(0, 255)));
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            do_write(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 4), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
